// File: rtl/checker_mpu_fetch_pkg.sv
// Shared constants, fetch-state encoding and buffer entry type for the checker MPU fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package checker_mpu_fetch_pkg;

    localparam int ADDR_W     = 15;
    localparam int INSN_W     = 48;
    localparam int INSN_BYTES = 6;
    localparam int MEM_BYTES  = 32768;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_ERROR = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INSN_W-1:0] insn;
    } fetch_ent_t;

endpackage

// File: rtl/checker_mpu_fetch_buf.sv
// Synchronous FIFO with flush; head entry is visible combinationally from storage.
// Latency: push visible at head the cycle after it is written.
// Backpressure: caller must never push when full without a same-cycle pop; flush wins over push/pop.
module checker_mpu_fetch_buf #(
    parameter int WIDTH = 63,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_dat = mem[rd_ptr];
    assign empty    = (count == '0);

endmodule

// File: rtl/checker_mpu_fetch.sv
// Instruction fetch: PC, RAM address issue, 1-cycle RAM return into a small FIFO toward the decoder.
// Latency: start in T -> issue T+1 -> data T+2 -> insn_valid_o T+3; 1 insn/cycle sustained.
// Backpressure: issue only when buffered + in-flight entries still fit after this cycle's pop.
module checker_mpu_fetch
    import checker_mpu_fetch_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic              stop_i,
    input  logic              jmp_i,
    input  logic [ADDR_W-1:0] jmp_addr_i,
    output logic [ADDR_W-1:0] i_addr_o,
    input  logic [INSN_W-1:0] i_data_i,
    output logic [INSN_W-1:0] insn_o,
    output logic [ADDR_W-1:0] insn_addr_o,
    output logic              insn_valid_o,
    input  logic              insn_ready_i,
    output logic              running_o,
    output logic              err_o
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    logic [1:0]        state;
    logic [ADDR_W:0]   pc;
    logic              inflight;
    logic [ADDR_W-1:0] tag_addr;
    logic              err_q;

    logic [CNT_W-1:0]  buf_count;
    logic              buf_empty;
    fetch_ent_t        head_ent;
    fetch_ent_t        push_ent;

    logic              run;
    logic              pop;
    logic              room;
    logic              overflow;
    logic              try_issue;
    logic              issue;
    logic              flush;
    logic              push;
    logic [CNT_W:0]    demand;

    assign run  = (state == ST_RUN);
    assign pop  = insn_valid_o & insn_ready_i;

    // pop implies a non-empty buffer, so this never underflows
    assign demand    = {1'b0, buf_count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    assign room      = demand < (CNT_W+1)'(BUF_DEPTH);
    // pc carries one extra bit so running off the top is seen here rather than wrapping to 0
    assign overflow  = pc > (ADDR_W+1)'(MEM_BYTES - INSN_BYTES);
    assign try_issue = run & ~stop_i & ~jmp_i & room;
    assign issue     = try_issue & ~overflow;
    assign flush     = stop_i | (run & jmp_i);
    assign push      = inflight & ~flush;

    assign push_ent.addr = tag_addr;
    assign push_ent.insn = i_data_i;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            pc       <= '0;
            inflight <= 1'b0;
            tag_addr <= '0;
            err_q    <= 1'b0;
        end else begin
            inflight <= issue;
            if (stop_i) begin
                state <= ST_IDLE;
            end else if (run) begin
                if (jmp_i) begin
                    pc <= {1'b0, jmp_addr_i};
                end else if (issue) begin
                    tag_addr <= pc[ADDR_W-1:0];
                    pc       <= pc + (ADDR_W+1)'(INSN_BYTES);
                end else if (try_issue) begin
                    state <= ST_ERROR;
                    err_q <= 1'b1;
                end
            end else if (start_i) begin
                state <= ST_RUN;
                pc    <= {1'b0, start_addr_i};
                err_q <= 1'b0;
            end
        end
    end

    checker_mpu_fetch_buf #(
        .WIDTH ($bits(fetch_ent_t)),
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .flush    (flush),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .head_dat (head_ent),
        .count    (buf_count),
        .empty    (buf_empty)
    );

    assign i_addr_o     = pc[ADDR_W-1:0];
    assign insn_o       = head_ent.insn;
    assign insn_addr_o  = head_ent.addr;
    assign insn_valid_o = ~buf_empty;
    assign running_o    = run;
    assign err_o        = err_q;

endmodule

// File: doc/checker_mpu_fetch.md
Name: checker_mpu_fetch

Overview:
Instruction fetch stage for the checker MPU.
- Holds the program counter and drives the 15-bit byte address to the byte-interleaved 8-bank instruction RAM mapper.
- Captures the returned 48-bit unaligned instruction word and hands it to the decoder over a valid/ready handshake.
- Absorbs the one-cycle synchronous RAM latency with a small output buffer.
- Handles start, stop, jump redirect and address-overflow error.

Parameters:
ADDR_W, 15, byte address width of instruction memory
INSN_W, 48, instruction width in bits
INSN_BYTES, 6, PC increment per sequential instruction
MEM_BYTES, 32768, instruction memory size in bytes
BUF_DEPTH, 2, output buffer entries (>=2 required for 1 insn/cycle)

Ports:
sys_clk  in  1  clock
sys_rst  in  1  reset, asynchronous, active-high
start_i  in  1  pulse: begin fetching at start_addr_i
start_addr_i  in  ADDR_W  initial PC
stop_i  in  1  pulse: halt and flush
jmp_i  in  1  pulse: redirect PC
jmp_addr_i  in  ADDR_W  redirect target
i_addr_o  out  ADDR_W  fetch byte address to RAM mapper
i_data_i  in  INSN_W  instruction word, valid one cycle after issue
insn_o  out  INSN_W  head-of-buffer instruction
insn_addr_o  out  ADDR_W  byte address of insn_o
insn_valid_o  out  1  insn_o valid
insn_ready_i  in  1  decoder accepts
running_o  out  1  state RUN
err_o  out  1  sticky fetch-overflow error

Behaviour:
- Reset values:
  - State IDLE.
  - pc=0, i_addr_o=0, buffer empty.
  - insn_valid_o=0, running_o=0, err_o=0.
  - insn_o=0, insn_addr_o=0.
- States:
  - IDLE: start_i -> RUN, pc<=start_addr_i, err cleared.
  - RUN: stop_i -> IDLE; overflow -> ERROR.
  - ERROR: start_i -> RUN as from IDLE.
- i_addr_o = pc (registered PC, combinational output).
- Issue condition: state RUN and (occupancy + inflight - pop) < BUF_DEPTH, where pop = insn_valid_o & insn_ready_i.
- On issue:
  - Set inflight and record tag address = pc.
  - pc <= pc + INSN_BYTES, computed at ADDR_W+1 bits.
- Return: the cycle after issue, i_data_i and the tag address are written to the buffer tail (end of that cycle); inflight clears.
- Latency:
  - start_i in cycle T -> issue in T+1 -> data in T+2 -> insn_valid_o in T+3.
  - Steady state 1 insn/cycle while insn_ready_i=1.
- Buffer is a FIFO; push and pop in the same cycle are both allowed. Push to a full buffer cannot occur by construction; the bench asserts this.
- Handshake:
  - insn_o and insn_addr_o are stable while insn_valid_o=1 and insn_ready_i=0.
  - Transfer occurs on a cycle with insn_valid_o=1 and insn_ready_i=1.
- Jump (jmp_i in RUN, cycle J):
  - Buffer flushed and inflight dropped at end of J; the word returning in J+1 is discarded.
  - pc <= jmp_addr_i; insn_valid_o=0 in J+1; first target insn valid in J+3.
  - A pop in cycle J still completes.
- Ignored inputs:
  - jmp_i in IDLE or ERROR.
  - start_i in RUN.
- Simultaneous events: stop_i > jmp_i > normal issue. start_i with stop_i in IDLE/ERROR -> remains IDLE.
- stop_i: flush buffer and inflight at end of cycle; pc is held.
- Overflow:
  - Detected when pc > MEM_BYTES - INSN_BYTES at the would-be issue cycle (pc wrap also counts).
  - No issue; state -> ERROR; err_o=1 sticky until start_i.
  - Buffered instructions already fetched still drain normally.
- Reset mid-operation (async assert) returns all state to reset values immediately. Release is synchronous to sys_clk via the codebase reset convention.

Decomposition:
- Shared checker MPU package:
  - Constants ADDR_W, INSN_W, INSN_BYTES, MEM_BYTES.
  - Fetch state encoding (IDLE, RUN, ERROR).
- One natural sub-module: checker_mpu_fetch_buf, the parameterised BUF_DEPTH synchronous FIFO carrying {addr, insn}, with flush, push, pop, count.

Test Plan:
- Reset: assert sys_rst mid-RUN -> all outputs 0 and state IDLE in the same cycle; no insn_valid_o after release until start_i.
- Sequential: start_addr_i=0, ready=1 -> insn_addr_o 0,6,12,18 on consecutive cycles from T+3; insn_o matches RAM model bytes.
- Backpressure: ready low for 5 cycles after first insn -> buffer reaches 2, issue stops, insn_o stable; on release addresses continue with no gap or duplicate.
- Jump: jmp_i with jmp_addr_i=0x0103 while streaming -> no stale insn after J; next insn_addr_o=0x0103 at J+3, then 0x0109.
- Overflow: start_addr_i=32756 -> insns at 32756 and 32762 delivered, then err_o=1, running_o=0; start_i clears err_o.
- Priority: stop_i and jmp_i in the same cycle -> IDLE, buffer empty, pc unchanged.
